din_conditioner: RTL and testbench

//   N-channel digital-input front end for the breakout-to-host path.
//   Per channel: metastability synchronizer, then a glitch filter with a runtime-set hold time.

---
 rtl/din_conditioner_if.sv | 30 +++
 rtl/din_conditioner.sv | 141 ++++++++++++++
 tb/tb_din_conditioner.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/din_conditioner_if.sv
// Signal bundle between the digital-input conditioner and its consumer.
// The master side is the conditioner; the slave side drives inputs and takes events.
interface din_conditioner_if #(
  parameter int N_CH   = 8,
  parameter int FILT_W = 8,
  parameter int CNT_W  = 16
) ();

  logic [N_CH-1:0]   i_d;
  logic [FILT_W-1:0] i_filt_clks;
  logic              i_en;
  logic              i_ready;
  logic [N_CH-1:0]   o_d;
  logic              o_valid;
  logic [N_CH-1:0]   o_state;
  logic [N_CH-1:0]   o_mask;
  logic              o_coalesced;
  logic [CNT_W-1:0]  o_evt_cnt;

  modport master (
    input  i_d, i_filt_clks, i_en, i_ready,
    output o_d, o_valid, o_state, o_mask, o_coalesced, o_evt_cnt
  );

  modport slave (
    output i_d, i_filt_clks, i_en, i_ready,
    input  o_d, o_valid, o_state, o_mask, o_coalesced, o_evt_cnt
  );

endinterface

// File: rtl/din_conditioner.sv
// N-channel digital-input front end: synchronizer, per-channel glitch filter,
// and edge-event capture with a valid/ready handshake, coalescing and lost-edge flag.
module din_conditioner #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  din_conditioner_if.master bus
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);

  typedef enum logic {EV_IDLE, EV_PENDING} ev_state_t;

  logic [N_CH-1:0]    sync_q [SYNC_STAGES];
  logic [N_CH-1:0]    sync_out;
  logic [FILT_W-1:0]  filt_cnt [N_CH];
  logic [FILT_W-1:0]  filt_cnt_next [N_CH];
  logic [N_CH-1:0]    d_q;
  logic [N_CH-1:0]    d_next;
  logic [N_CH-1:0]    chg;
  logic [PRIME_W-1:0] prime_cnt;
  logic               prime_done;

  ev_state_t          ev_q, ev_next;
  logic [N_CH-1:0]    mask_q, mask_next;
  logic [N_CH-1:0]    state_q, state_next;
  logic               coal_q, coal_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.i_d;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign prime_done = (prime_cnt == '0);

  // While priming, o_d simply tracks the synchronizer so idle-high pads never look like edges.
  // A shrunken hold count takes effect at once, hence >= rather than ==.
  always_comb begin
    d_next = d_q;
    for (int c = 0; c < N_CH; c++) begin
      filt_cnt_next[c] = '0;
      if (!prime_done) begin
        d_next[c] = sync_out[c];
      end else if (sync_out[c] != d_q[c]) begin
        if (filt_cnt[c] >= bus.i_filt_clks) begin
          d_next[c] = sync_out[c];
        end else begin
          filt_cnt_next[c] = filt_cnt[c] + FILT_W'(1);
        end
      end
    end
  end

  assign chg = (d_next ^ d_q) & {N_CH{bus.i_en & prime_done}};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      d_q       <= '0;
      prime_cnt <= PRIME_LOAD;
      for (int c = 0; c < N_CH; c++) filt_cnt[c] <= '0;
    end else begin
      d_q <= d_next;
      if (!prime_done) prime_cnt <= prime_cnt - PRIME_W'(1);
      for (int c = 0; c < N_CH; c++) filt_cnt[c] <= filt_cnt_next[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ev_q    <= EV_IDLE;
      mask_q  <= '0;
      state_q <= '0;
      coal_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ev_q    <= ev_next;
      mask_q  <= mask_next;
      state_q <= state_next;
      coal_q  <= coal_next;
      cnt_q   <= cnt_next;
    end
  end

  // An accept with a same-cycle change reloads immediately so back-to-back edges cost no bubble;
  // a stalled consumer sees changes merged, with the lost-edge flag set on a repeat toggle.
  always_comb begin
    ev_next    = ev_q;
    mask_next  = mask_q;
    state_next = state_q;
    coal_next  = coal_q;
    cnt_next   = cnt_q;
    case (ev_q)
      EV_IDLE: begin
        if (|chg) begin
          ev_next    = EV_PENDING;
          mask_next  = chg;
          state_next = d_next;
          coal_next  = 1'b0;
        end
      end
      EV_PENDING: begin
        if (bus.i_ready) begin
          cnt_next = cnt_q + CNT_W'(1);
          if (|chg) begin
            mask_next  = chg;
            state_next = d_next;
            coal_next  = 1'b0;
          end else begin
            ev_next   = EV_IDLE;
            mask_next = '0;
            coal_next = 1'b0;
          end
        end else if (|chg) begin
          mask_next  = mask_q | chg;
          state_next = d_next;
          coal_next  = coal_q | (|(mask_q & chg));
        end
      end
      default: ev_next = EV_IDLE;
    endcase
  end

  assign bus.o_d         = d_q;
  assign bus.o_valid     = (ev_q == EV_PENDING);
  assign bus.o_state     = state_q;
  assign bus.o_mask      = mask_q;
  assign bus.o_coalesced = coal_q;
  assign bus.o_evt_cnt   = cnt_q;

endmodule

// File: tb/tb_din_conditioner.sv
// Bench for din_conditioner: directed vectors and sequences plus randomized traffic
// checked every cycle against a run-length/toggle-count reference model.
module tb_din_conditioner;

  localparam int N_CH   = 8;
  localparam int SYNC   = 2;
  localparam int FILT_W = 8;
  localparam int CNT_W  = 16;

  typedef struct {
    int filt;
    int len;
    bit pass;
    int lat;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d     = 8'hFF;
  logic [7:0] filt  = 8'd3;
  logic       en    = 1'b1;
  logic       ready = 1'b0;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;
  int rch;

  always #5 clk = ~clk;

  din_conditioner_if #(.N_CH(N_CH), .FILT_W(FILT_W), .CNT_W(CNT_W)) bus ();
  din_conditioner_if #(.N_CH(N_CH), .FILT_W(FILT_W), .CNT_W(2))     bus_w ();

  assign bus.i_d           = d;
  assign bus.i_filt_clks   = filt;
  assign bus.i_en          = en;
  assign bus.i_ready       = ready;
  assign bus_w.i_d         = d;
  assign bus_w.i_filt_clks = filt;
  assign bus_w.i_en        = en;
  assign bus_w.i_ready     = ready;

  din_conditioner #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus)
  );

  din_conditioner #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(2)) dut_w (
    .i_clk(clk), .i_reset(reset), .bus(bus_w)
  );

  logic [7:0] m_od, m_state, m_mask;
  logic       m_valid, m_coal;
  int         m_cnt, m_post;
  int         tcnt [N_CH];
  logic [7:0] hist [$];
  logic [7:0] shist [$];

  // Reference: a level passes once the last filt+1 synchronized samples all disagree with o_d;
  // pending-event bookkeeping is kept as per-channel toggle counts since the last accept.
  always @(posedge clk) begin
    logic [7:0] s, nod, chg, v;
    bit ok;
    if (reset) begin
      m_od = '0; m_state = '0; m_mask = '0; m_valid = 0; m_coal = 0;
      m_cnt = 0; m_post = 0;
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back(8'h00);
      shist.delete();
      for (int c = 0; c < N_CH; c++) tcnt[c] = 0;
    end else begin
      m_post++;
      s = hist.pop_front();
      hist.push_back(d);
      shist.push_back(s);
      if (shist.size() > 300) void'(shist.pop_front());
      nod = m_od;
      if (m_post <= SYNC + 1) begin
        nod = s;
      end else begin
        for (int c = 0; c < N_CH; c++) begin
          ok = (shist.size() >= int'(filt) + 1);
          for (int k = 0; ok && k <= int'(filt); k++) begin
            v = shist[shist.size() - 1 - k];
            if (v[c] == m_od[c]) ok = 0;
          end
          if (ok) nod[c] = s[c];
        end
      end
      chg = (en && m_post > SYNC + 1) ? (nod ^ m_od) : 8'h00;
      if (!m_valid) begin
        if (chg != 0) begin
          m_valid = 1; m_state = nod;
          for (int c = 0; c < N_CH; c++) tcnt[c] = int'(chg[c]);
        end
      end else if (ready) begin
        m_cnt++;
        if (chg != 0) begin
          m_state = nod;
          for (int c = 0; c < N_CH; c++) tcnt[c] = int'(chg[c]);
        end else begin
          m_valid = 0;
          for (int c = 0; c < N_CH; c++) tcnt[c] = 0;
        end
      end else if (chg != 0) begin
        m_state = nod;
        for (int c = 0; c < N_CH; c++) tcnt[c] += int'(chg[c]);
      end
      m_od = nod;
      m_coal = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_mask[c] = (tcnt[c] > 0);
        if (tcnt[c] > 1) m_coal = 1;
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check_val("model_o_d",       32'(bus.o_d),         32'(m_od));
    check_val("model_valid",     32'(bus.o_valid),     32'(m_valid));
    check_val("model_mask",      32'(bus.o_mask),      32'(m_mask));
    check_val("model_state",     32'(bus.o_state),     32'(m_state));
    check_val("model_coalesced", 32'(bus.o_coalesced), 32'(m_coal));
    check_val("model_evt_cnt",   32'(bus.o_evt_cnt),   32'(m_cnt % 65536));
    check_val("model_evt_cnt_w", 32'(bus_w.o_evt_cnt), 32'(m_cnt % 4));
  endtask

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (model_on) check_output();
    end
  endtask

  initial begin
    vec_t vecs [7];
    bit   seen;
    int   nvalid;

    vecs[0] = '{3, 3, 1'b0, 0};
    vecs[1] = '{3, 4, 1'b1, 6};
    vecs[2] = '{0, 1, 1'b1, 3};
    vecs[3] = '{2, 2, 1'b0, 0};
    vecs[4] = '{2, 3, 1'b1, 5};
    vecs[5] = '{5, 6, 1'b1, 8};
    vecs[6] = '{1, 1, 1'b0, 0};

    $display("[TB] start");

    // idle-high inputs through reset: prime absorbs them
    apply_stimulus(3);
    model_on = 1;
    reset = 0;
    apply_stimulus(2);
    check_val("prime_early_od", 32'(bus.o_d), 32'h00);
    apply_stimulus(1);
    check_val("prime_od", 32'(bus.o_d), 32'hFF);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1);
      check_val("prime_no_valid", 32'(bus.o_valid), 32'h0);
    end

    // filter pulse-width table on ch0
    ready = 1;
    for (int r = 0; r < 7; r++) begin
      filt = 8'(vecs[r].filt);
      apply_stimulus(12);
      d[0] = 1'b0;
      seen = 0;
      for (int k = 1; k <= 30; k++) begin
        if (k == vecs[r].len + 1) d[0] = 1'b1;
        apply_stimulus(1);
        if (!seen && bus.o_d[0] == 1'b0) begin
          seen = 1;
          check_val($sformatf("vec%0d_latency", r), 32'(k), 32'(vecs[r].lat));
          check_val($sformatf("vec%0d_valid", r), 32'(bus.o_valid), 32'h1);
          check_val($sformatf("vec%0d_mask", r), 32'(bus.o_mask), 32'h01);
          check_val($sformatf("vec%0d_state", r), 32'(bus.o_state), 32'hFE);
        end
      end
      check_val($sformatf("vec%0d_pass", r), 32'(seen), 32'(vecs[r].pass));
    end

    // coalescing while the consumer stalls
    filt = 8'd0;
    apply_stimulus(10);
    ready = 0;
    d[1] = 1'b0;
    apply_stimulus(5);
    d[2] = 1'b0;
    apply_stimulus(5);
    check_val("coal_valid", 32'(bus.o_valid), 32'h1);
    check_val("coal_mask", 32'(bus.o_mask), 32'h06);
    check_val("coal_flag0", 32'(bus.o_coalesced), 32'h0);
    check_val("coal_state0", 32'(bus.o_state), 32'hF9);
    d[1] = 1'b1;
    apply_stimulus(5);
    check_val("coal_flag1", 32'(bus.o_coalesced), 32'h1);
    check_val("coal_mask1", 32'(bus.o_mask), 32'h06);
    check_val("coal_state1", 32'(bus.o_state), 32'hFB);
    ready = 1;
    apply_stimulus(1);
    d = 8'hFF;
    apply_stimulus(10);

    // reset while an event is pending
    ready = 0;
    d[1] = 1'b0;
    apply_stimulus(5);
    check_val("rst_pre_valid", 32'(bus.o_valid), 32'h1);
    reset = 1;
    apply_stimulus(1);
    check_val("rst_valid", 32'(bus.o_valid), 32'h0);
    check_val("rst_mask", 32'(bus.o_mask), 32'h00);
    check_val("rst_evt_cnt", 32'(bus.o_evt_cnt), 32'h0);
    check_val("rst_evt_cnt_w", 32'(bus_w.o_evt_cnt), 32'h0);
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1);
      check_val("rst_no_valid", 32'(bus.o_valid), 32'h0);
    end
    check_val("rst_od_held", 32'(bus.o_d), 32'hFD);

    // back-to-back single-bit events, then counter wrap on the narrow instance
    ready = 1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 4) d[k] = ~d[k];
      apply_stimulus(1);
      if (bus.o_valid) begin
        nvalid++;
        check_val("b2b_onehot", 32'($countones(bus.o_mask)), 32'h1);
      end
    end
    check_val("b2b_events", 32'(nvalid), 32'h4);
    check_val("b2b_evt_cnt", 32'(bus.o_evt_cnt), 32'h4);
    d[4] = ~d[4];
    apply_stimulus(6);
    check_val("wrap_evt_cnt", 32'(bus.o_evt_cnt), 32'h5);
    check_val("wrap_evt_cnt_w", 32'(bus_w.o_evt_cnt), 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        rch = int'($urandom_range(0, 7));
        d[rch] = ~d[rch];
      end
      if ($urandom_range(0, 199) == 0) filt = 8'($urandom_range(0, 4));
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 999) == 0);
      apply_stimulus(1);
    end
    reset = 0;
    apply_stimulus(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
